// File: rtl/axi_wb_arbiter_pkg.sv
// Shared definitions for the two-requester AXI write-burst scheduler:
// FSM state encoding and the fixed AXI burst attributes.
package axi_wb_pkg;

    // FSM state encoding (plain constants so older tools can consume it)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_AW    = 3'd1;
    localparam logic [2:0] ST_RD    = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_W     = 3'd4;
    localparam logic [2:0] ST_B     = 3'd5;

    // Fixed AXI burst attributes: incrementing bursts of 32-bit words
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

endpackage

// File: rtl/axi_wb_arbiter_if.sv
// AXI write-channel bundle (AW/W/B) shared by the scheduler and its target.
interface axi_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;

    // Scheduler side: drives address/data, receives ready and response
    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bvalid
    );

    // Write target side
    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bvalid
    );
endinterface

// File: rtl/axi_wb_arbiter_wb_rr_arb2.sv
// Combinational two-way round-robin pick. On a tie the requester that was
// not granted last time wins; a single request is granted directly.
module wb_rr_arb2 (
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Pick the winner from the current requests and the previous grant
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/axi_wb_arbiter.sv
// Two-requester write-burst scheduler onto one AXI write port. Grants a
// requester round-robin, issues AW, then for each beat pops the granted
// FIFO (RD), captures the word (FETCH) and presents it on W, and finally
// waits for the B response before returning to IDLE.
// DATA_WIDTH must be 32: awsize and wstrb are fixed for 4-byte beats.
module axi_wb_arbiter
    import axi_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [LEN_WIDTH-1:0]  req0_len,
    output logic                  req0_ready,
    output logic                  req0_done,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [LEN_WIDTH-1:0]  req1_len,
    output logic                  req1_ready,
    output logic                  req1_done,
    input  logic                  in0_read_ready,
    output logic                  in0_read_valid,
    input  logic [DATA_WIDTH-1:0] in0_out_data,
    input  logic                  in1_read_ready,
    output logic                  in1_read_valid,
    input  logic [DATA_WIDTH-1:0] in1_out_data,
    axi_wb_arbiter_if.master      s_axi
);

    logic [2:0]            state;
    logic                  last_grant;
    logic                  grant_id;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [DATA_WIDTH-1:0] wdata_reg;

    logic arb_valid;
    logic arb_id;
    logic fifo_ready;
    logic beat_last;
    logic accept;

    wb_rr_arb2 u_arb (
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .last_grant  (last_grant),
        .grant_valid (arb_valid),
        .grant_id    (arb_id)
    );

    // Only the granted FIFO's status matters; beat_cnt reaching len_reg ends
    // the burst before the counter could wrap, even for len = all ones.
    assign fifo_ready = grant_id ? in1_read_ready : in0_read_ready;
    assign beat_last  = (beat_cnt == len_reg);
    // rst gates the accept pulse so the ready outputs read 0 during reset
    assign accept     = rst && (state == ST_IDLE) && arb_valid;

    // Burst sequencing FSM with latched descriptor, beat counter and W data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            addr_reg   <= '0;
            len_reg    <= '0;
            beat_cnt   <= '0;
            wdata_reg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_id   <= arb_id;
                        last_grant <= arb_id;
                        addr_reg   <= arb_id ? req1_addr : req0_addr;
                        len_reg    <= arb_id ? req1_len : req0_len;
                        beat_cnt   <= '0;
                        state      <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (s_axi.awready) state <= ST_RD;
                end
                ST_RD: begin
                    if (fifo_ready) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    wdata_reg <= grant_id ? in1_out_data : in0_out_data;
                    state     <= ST_W;
                end
                ST_W: begin
                    if (s_axi.wready) begin
                        if (beat_last) begin
                            state <= ST_B;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            state    <= ST_RD;
                        end
                    end
                end
                ST_B: begin
                    if (s_axi.bvalid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req0_ready = accept && !arb_id;
    assign req1_ready = accept && arb_id;

    assign in0_read_valid = (state == ST_RD) && !grant_id && in0_read_ready;
    assign in1_read_valid = (state == ST_RD) && grant_id && in1_read_ready;

    assign req0_done = (state == ST_B) && s_axi.bvalid && !grant_id;
    assign req1_done = (state == ST_B) && s_axi.bvalid && grant_id;

    assign s_axi.awaddr  = addr_reg;
    assign s_axi.awlen   = 8'(len_reg);
    assign s_axi.awsize  = AXI_SIZE_4B;
    assign s_axi.awburst = AXI_BURST_INCR;
    assign s_axi.awvalid = (state == ST_AW);

    assign s_axi.wvalid  = (state == ST_W);
    assign s_axi.wdata   = wdata_reg;
    assign s_axi.wstrb   = (state == ST_W) ? 4'hF : 4'h0;
    assign s_axi.wlast   = (state == ST_W) && beat_last;

    assign s_axi.bready  = (state == ST_B);

endmodule

// File: tb/tb_axi_wb_arbiter.sv
// Directed bench for axi_wb_arbiter: FIFO models per requester, a handshake
// logger on the falling edge, and a linear sequence of scenarios.
module tb_axi_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_addr, req1_addr;
    logic [7:0]  req0_len, req1_len;
    logic        req0_ready, req1_ready, req0_done, req1_done;
    logic        in0_read_ready, in1_read_ready;
    logic        in0_read_valid, in1_read_valid;
    logic [31:0] in0_out_data = '0;
    logic [31:0] in1_out_data = '0;

    axi_wb_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

    axi_wb_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_len       (req0_len),
        .req0_ready     (req0_ready),
        .req0_done      (req0_done),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_len       (req1_len),
        .req1_ready     (req1_ready),
        .req1_done      (req1_done),
        .in0_read_ready (in0_read_ready),
        .in0_read_valid (in0_read_valid),
        .in0_out_data   (in0_out_data),
        .in1_read_ready (in1_read_ready),
        .in1_read_valid (in1_read_valid),
        .in1_out_data   (in1_out_data),
        .s_axi          (axi)
    );

    always #5 clk = ~clk;

    // FIFO models: pushed by the sequence, popped on the DUT strobe
    logic [31:0] mem0 [0:63];
    logic [31:0] mem1 [0:63];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    assign in0_read_ready = (rd0 != wr0);
    assign in1_read_ready = (rd1 != wr1);

    always @(posedge clk) begin
        if (in0_read_valid) begin
            in0_out_data <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (in1_read_valid) begin
            in1_out_data <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    // Handshake logger
    logic [15:0] aw_addr_log [0:63];
    logic [7:0]  aw_len_log  [0:63];
    logic [31:0] w_data_log  [0:255];
    logic        w_last_log  [0:255];
    logic        grant_log   [0:63];
    int aw_cnt = 0, w_cnt = 0, g_cnt = 0;
    int pop0 = 0, pop1 = 0, done0 = 0, done1 = 0;

    always @(negedge clk) begin
        if (axi.awvalid && axi.awready) begin
            aw_addr_log[aw_cnt] <= axi.awaddr;
            aw_len_log[aw_cnt]  <= axi.awlen;
            aw_cnt <= aw_cnt + 1;
        end
        if (axi.wvalid && axi.wready) begin
            w_data_log[w_cnt] <= axi.wdata;
            w_last_log[w_cnt] <= axi.wlast;
            w_cnt <= w_cnt + 1;
        end
        if (req0_ready) begin
            grant_log[g_cnt] <= 1'b0;
            g_cnt <= g_cnt + 1;
        end else if (req1_ready) begin
            grant_log[g_cnt] <= 1'b1;
            g_cnt <= g_cnt + 1;
        end
        if (in0_read_valid) pop0 <= pop0 + 1;
        if (in1_read_valid) pop1 <= pop1 + 1;
        if (req0_done) done0 <= done0 + 1;
        if (req1_done) done1 <= done1 + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [31:0] d);
        mem0[wr0] = d;
        wr0++;
    endtask

    task automatic push1(input logic [31:0] d);
        mem1[wr1] = d;
        wr1++;
    endtask

    // Present a descriptor and hold it until the accept pulse has been taken
    task automatic issue(input int id, input logic [15:0] a, input logic [7:0] l);
        logic ok;
        ok = 1'b0;
        if (id == 0) begin
            req0_addr = a; req0_len = l; req0_valid = 1'b1;
        end else begin
            req1_addr = a; req1_len = l; req1_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if ((id == 0) ? req0_ready : req1_ready) ok = 1'b1;
            step();
        end
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
        chk($sformatf("issue%0d_accept", id), 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input int id, input int base, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step();
            if (((id == 0) ? done0 : done1) > base) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_beats(input int target, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            step();
            if (w_cnt >= target) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_wvalid(input string tag);
        for (int i = 0; i < 100 && !axi.wvalid; i++) step();
        chk(tag, 64'(axi.wvalid), 64'd1);
    endtask

    int b_aw, b_w, b_g, b_p0, b_p1, b_d0, b_d1;

    task automatic snap();
        b_aw = aw_cnt; b_w = w_cnt; b_g = g_cnt;
        b_p0 = pop0; b_p1 = pop1; b_d0 = done0; b_d1 = done1;
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;

        // Reset state
        step(); step();
        chk("rst_awvalid", 64'(axi.awvalid), 64'd0);
        chk("rst_wvalid",  64'(axi.wvalid),  64'd0);
        chk("rst_wstrb",   64'(axi.wstrb),   64'd0);
        chk("rst_wlast",   64'(axi.wlast),   64'd0);
        chk("rst_bready",  64'(axi.bready),  64'd0);
        chk("rst_awaddr",  64'(axi.awaddr),  64'd0);
        chk("rst_awsize",  64'(axi.awsize),  64'd2);
        chk("rst_awburst", 64'(axi.awburst), 64'd1);
        rst = 1'b1;
        step();

        // Basic burst on requester 0
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1;
        push0(32'h11); push0(32'h22); push0(32'h33); push0(32'h44);
        snap();
        issue(0, 16'h0100, 8'd3);
        chk("t1_aw_latency", 64'(axi.awvalid), 64'd1);
        wait_done(0, b_d0, "t1_done");
        chk("t1_aw_count", 64'(aw_cnt - b_aw), 64'd1);
        chk("t1_awaddr",   64'(aw_addr_log[b_aw]), 64'h0100);
        chk("t1_awlen",    64'(aw_len_log[b_aw]),  64'd3);
        chk("t1_beats",    64'(w_cnt - b_w), 64'd4);
        chk("t1_d0", 64'(w_data_log[b_w+0]), 64'h11);
        chk("t1_d1", 64'(w_data_log[b_w+1]), 64'h22);
        chk("t1_d2", 64'(w_data_log[b_w+2]), 64'h33);
        chk("t1_d3", 64'(w_data_log[b_w+3]), 64'h44);
        chk("t1_l0", 64'(w_last_log[b_w+0]), 64'd0);
        chk("t1_l2", 64'(w_last_log[b_w+2]), 64'd0);
        chk("t1_l3", 64'(w_last_log[b_w+3]), 64'd1);
        chk("t1_pop0", 64'(pop0 - b_p0), 64'd4);
        chk("t1_pop1", 64'(pop1 - b_p1), 64'd0);
        chk("t1_done1", 64'(done1 - b_d1), 64'd0);
        chk("t1_grants", 64'(g_cnt - b_g), 64'd1);
        step();

        // Round robin from reset with both requesters continuously valid
        push0(32'hA0); push0(32'hA1); push0(32'hA2);
        push1(32'hB0); push1(32'hB1); push1(32'hB2);
        req0_addr = 16'h0200; req0_len = 8'd0;
        req1_addr = 16'h0300; req1_len = 8'd0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk("t2_rst_ready0", 64'(req0_ready), 64'd0);
        chk("t2_rst_ready1", 64'(req1_ready), 64'd0);
        step();
        snap();
        rst = 1'b1;
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 400 && !ok; i++) begin
                step();
                if (g_cnt >= b_g + 6) ok = 1'b1;
            end
            chk("t2_six_grants", 64'(ok), 64'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_done(1, done1, "t2_done");
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_d;
            exp_d = (i % 2 == 0) ? (32'hA0 + 32'(i / 2)) : (32'hB0 + 32'(i / 2));
            chk($sformatf("t2_grant%0d", i), 64'(grant_log[b_g+i]), 64'(i % 2));
            chk($sformatf("t2_data%0d", i), 64'(w_data_log[b_w+i]), 64'(exp_d));
            chk($sformatf("t2_awaddr%0d", i), 64'(aw_addr_log[b_aw+i]),
                (i % 2 == 0) ? 64'h0200 : 64'h0300);
        end
        chk("t2_pop0", 64'(pop0 - b_p0), 64'd3);
        chk("t2_pop1", 64'(pop1 - b_p1), 64'd3);
        step();

        // Backpressure on AW then on W beat 2
        push0(32'hC0); push0(32'hC1); push0(32'hC2); push0(32'hC3);
        axi.awready = 1'b0;
        snap();
        issue(0, 16'h0400, 8'd3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_awvalid%0d", i), 64'(axi.awvalid), 64'd1);
            chk($sformatf("t3_awaddr%0d", i),  64'(axi.awaddr),  64'h0400);
            chk($sformatf("t3_awlen%0d", i),   64'(axi.awlen),   64'd3);
            step();
        end
        axi.awready = 1'b1;
        wait_beats(b_w + 1, "t3_first_beat");
        axi.wready = 1'b0;
        wait_wvalid("t3_beat2_present");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_wvalid%0d", i), 64'(axi.wvalid), 64'd1);
            chk($sformatf("t3_wdata%0d", i),  64'(axi.wdata),  64'hC1);
            chk($sformatf("t3_wlast%0d", i),  64'(axi.wlast),  64'd0);
            chk($sformatf("t3_pops%0d", i),   64'(pop0 - b_p0), 64'd2);
            chk($sformatf("t3_beats%0d", i),  64'(w_cnt - b_w), 64'd1);
            step();
        end
        axi.wready = 1'b1;
        wait_done(0, b_d0, "t3_done");
        chk("t3_aw_count", 64'(aw_cnt - b_aw), 64'd1);
        chk("t3_beats", 64'(w_cnt - b_w), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_d%0d", i), 64'(w_data_log[b_w+i]), 64'(32'hC0 + 32'(i)));
            chk($sformatf("t3_l%0d", i), 64'(w_last_log[b_w+i]), 64'(i == 3));
        end
        chk("t3_pop0", 64'(pop0 - b_p0), 64'd4);
        step();

        // FIFO underflow stall on requester 1
        push1(32'hD0);
        snap();
        issue(1, 16'h0500, 8'd2);
        wait_beats(b_w + 1, "t4_first_beat");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_stall_pop%0d", i), 64'(in1_read_valid), 64'd0);
            chk($sformatf("t4_stall_w%0d", i),   64'(axi.wvalid),     64'd0);
            step();
        end
        push1(32'hD1); push1(32'hD2);
        wait_done(1, b_d1, "t4_done");
        chk("t4_beats", 64'(w_cnt - b_w), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_d%0d", i), 64'(w_data_log[b_w+i]), 64'(32'hD0 + 32'(i)));
            chk($sformatf("t4_l%0d", i), 64'(w_last_log[b_w+i]), 64'(i == 2));
        end
        chk("t4_pop1", 64'(pop1 - b_p1), 64'd3);
        chk("t4_pop0", 64'(pop0 - b_p0), 64'd0);
        step();

        // Single-beat burst
        push1(32'hDEADBEEF);
        snap();
        issue(1, 16'h0600, 8'd0);
        wait_done(1, b_d1, "t5_done");
        chk("t5_awaddr", 64'(aw_addr_log[b_aw]), 64'h0600);
        chk("t5_awlen",  64'(aw_len_log[b_aw]),  64'd0);
        chk("t5_beats",  64'(w_cnt - b_w), 64'd1);
        chk("t5_data",   64'(w_data_log[b_w]), 64'hDEADBEEF);
        chk("t5_wlast",  64'(w_last_log[b_w]), 64'd1);
        chk("t5_done1",  64'(done1 - b_d1), 64'd1);
        chk("t5_done0",  64'(done0 - b_d0), 64'd0);
        step();

        // Reset in the middle of a burst
        axi.wready = 1'b0;
        push0(32'hE0); push0(32'hE1); push0(32'hE2);
        issue(0, 16'h0700, 8'd2);
        wait_wvalid("t6_in_w");
        req1_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk("t6_awvalid", 64'(axi.awvalid), 64'd0);
        chk("t6_wvalid",  64'(axi.wvalid),  64'd0);
        chk("t6_wstrb",   64'(axi.wstrb),   64'd0);
        chk("t6_wlast",   64'(axi.wlast),   64'd0);
        chk("t6_bready",  64'(axi.bready),  64'd0);
        chk("t6_awaddr",  64'(axi.awaddr),  64'd0);
        chk("t6_awlen",   64'(axi.awlen),   64'd0);
        chk("t6_wdata",   64'(axi.wdata),   64'd0);
        chk("t6_ready1",  64'(req1_ready),  64'd0);
        chk("t6_pop0",    64'(in0_read_valid), 64'd0);
        step();
        rst = 1'b1;
        axi.wready = 1'b1;
        push1(32'hF0); push1(32'hF1);
        snap();
        issue(1, 16'h0800, 8'd1);
        wait_done(1, b_d1, "t6_done");
        chk("t6_grant",    64'(grant_log[b_g]), 64'd1);
        chk("t6_awaddr2",  64'(aw_addr_log[b_aw]), 64'h0800);
        chk("t6_beats",    64'(w_cnt - b_w), 64'd2);
        chk("t6_d0",       64'(w_data_log[b_w+0]), 64'hF0);
        chk("t6_d1",       64'(w_data_log[b_w+1]), 64'hF1);
        chk("t6_l1",       64'(w_last_log[b_w+1]), 64'd1);
        chk("t6_pop1",     64'(pop1 - b_p1), 64'd2);
        chk("t6_pop0_none", 64'(pop0 - b_p0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_wb_arbiter.md
Name: axi_wb_arbiter

Overview:
- Two-requester write-burst scheduler that shares one AXI write slave port (AW/W/B channels) between two streaming sources.
- Each requester presents a burst descriptor (address, length) and a FIFO data stream. The block grants requesters round-robin, issues AW, pops FIFO words into W beats with wlast, then waits for B before the next grant.
- Sits between the HLS-generated stream writers and the shared AXI write target.

Parameters:
ADDR_WIDTH, 16, AXI address and descriptor address width
DATA_WIDTH, 32, FIFO word and W data width; must be 32 (awsize fixed to 3'd2)
LEN_WIDTH, 8, descriptor length width; value = beats-1 (AXI awlen encoding)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (asserted when 0)
req0_valid / req1_valid  in  1  descriptor valid; held stable until accepted
req0_addr / req1_addr  in  ADDR_WIDTH  burst start address
req0_len / req1_len  in  LEN_WIDTH  beats-1
req0_ready / req1_ready  out  1  one-cycle descriptor-accept pulse
req0_done / req1_done  out  1  one-cycle burst-complete pulse
in0_read_ready / in1_read_ready  in  1  FIFO non-empty
in0_read_valid / in1_read_valid  out  1  FIFO pop strobe
in0_out_data / in1_out_data  in  DATA_WIDTH  FIFO head data, valid the cycle after the pop
s_axi_awaddr  out  ADDR_WIDTH  burst address
s_axi_awlen  out  8  burst length
s_axi_awsize  out  3  constant 3'd2
s_axi_awburst  out  2  constant 2'b01 (INCR)
s_axi_awvalid  out  1  address valid
s_axi_awready  in  1  address accepted
s_axi_wdata  out  DATA_WIDTH  beat data
s_axi_wstrb  out  4  4'hF when wvalid, else 0
s_axi_wlast  out  1  final beat
s_axi_wvalid  out  1  beat valid
s_axi_wready  in  1  beat accepted
s_axi_bvalid  in  1  write response valid
s_axi_bready  out  1  response ready

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - All outputs are 0 except the awsize/awburst constants.
  - beat_cnt=0; last_grant=1, so req0 wins the first tie.
  - Any in-flight AXI transaction is abandoned.
- IDLE:
  - If either reqN_valid is high, grant N. If both are high, grant the requester other than last_grant.
  - Latch addr, len and grant; set last_grant=N; pulse reqN_ready for that cycle; clear beat_cnt; go to AW.
- AW:
  - awvalid=1; awaddr and awlen come from the latched registers and stay stable while awready=0.
  - On awready, go to RD.
- RD:
  - If inN_read_ready, pulse inN_read_valid for one cycle and go to FETCH; otherwise stay.
  - No wvalid is driven while in RD.
- FETCH: capture inN_out_data into wdata_reg; go to W.
- W:
  - wvalid=1, wdata=wdata_reg, wstrb=4'hF, wlast=(beat_cnt==len_reg). Data stays stable while wready=0.
  - On wready: if wlast, go to B; else beat_cnt+1 and go to RD.
- B:
  - bready=1. On bvalid, pulse reqN_done in the same cycle (combinational) and go to IDLE.
  - The bresp value is ignored.
- Throughput and latency:
  - Minimum 3 cycles per beat.
  - Descriptor accept to awvalid: 1 cycle.
- Boundary conditions:
  - len=0 gives a single beat with wlast on that beat.
  - len=255 gives 256 beats; beat_cnt is LEN_WIDTH bits and never wraps, because the compare terminates the burst first.
  - The non-granted requester's valid is ignored until IDLE. A new request arriving in the same cycle as bvalid is seen in the following IDLE cycle.
  - Only the granted FIFO is ever popped.

Decomposition:
- Shared package axi_wb_pkg holds:
  - state encoding (IDLE, AW, RD, FETCH, W, B);
  - AXI_BURST_INCR=2'b01 and AXI_SIZE_4B=3'd2.
- One sub-module, wb_rr_arb2: combinational 2-way round-robin pick from (req0_valid, req1_valid, last_grant) → (grant_valid, grant_id).
- The FSM, beat counter and datapath registers stay in axi_wb_arbiter.

Test Plan:
1. Basic burst: req0 addr=0x0100 len=3; FIFO0 words 0x11,0x22,0x33,0x44; awready=wready=bvalid=1 → one AW with awaddr=0x0100 awlen=3, four W beats in order, wlast only on 0x44, then req0_done pulse; req1 signals idle.
2. Round-robin: req0 and req1 both valid from reset → req0 burst first, then req1. Re-assert both → req0 again (last_grant=1). A stream of 4 tied requests must grant 0,1,0,1.
3. Backpressure: awready held low 5 cycles, then wready low on beat 2 for 3 cycles → awvalid/awaddr and wvalid/wdata held stable; no extra FIFO pops; beat count unchanged.
4. FIFO underflow stall: in1_read_ready=0 for 4 cycles mid-burst → no in1_read_valid and no wvalid during the stall; the burst resumes with correct data and total beats = len+1.
5. Single beat: req1 len=0, data 0xDEADBEEF → one beat with wlast=1, then B and req1_done.
6. Reset mid-burst: drive rst=0 during W of beat 1 → all outputs 0 in the same cycle. After release, a new req1-only request is accepted and completes normally.
